regbank_arbiter: RTL and testbench
==================================

Name: regbank_arbiter

Overview:
- Shares the single-port 16x8 time/chronometer register bank between two requesters.
- Requester 1 is the VGA display controller (read-only). Requester 2 is the RTC/update interface (read and write).
- Fixed-priority arbitration depends on the video blanking flag, with a starvation guard for the RTC side.
- One transaction is in flight at a time. The block drives the bank's address, write-enable and write-data lines directly.

Parameters:
- RD_LAT, 1, bank read latency in cycles (MemAddrOut to MemDataIN valid); legal 1..3.
- MAX_WAIT, 8, cycles an RTC request may be blocked during active video before it is forced through; legal 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- in_blank  in  1  1 during horizontal/vertical blanking.
- vga_req  in  1  VGA read request; held with vga_addr until vga_gnt.
- vga_addr  in  4  VGA register address.
- vga_gnt  out  1  one-cycle pulse when the VGA request is issued to the bank.
- vga_data  out  8  VGA read data; valid from vga_valid, held until the next VGA read completes.
- vga_valid  out  1  one-cycle pulse when vga_data is updated.
- rtc_req  in  1  RTC request; held with rtc_we/rtc_addr/rtc_wdata until rtc_gnt.
- rtc_we  in  1  1 = write, 0 = read.
- rtc_addr  in  4  RTC register address.
- rtc_wdata  in  8  RTC write data.
- rtc_gnt  out  1  one-cycle issue pulse.
- rtc_rdata  out  8  RTC read data; held as for vga_data.
- rtc_valid  out  1  one-cycle completion pulse, for reads and writes.
- MemAddrOut  out  4  bank address.
- MemDataOut  out  8  bank write data.
- MemWE  out  1  bank write enable.
- MemDataIN  in  8  bank read data.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including MemWE, which drops immediately.
  - The wait counter clears.
  - Any in-flight transaction is abandoned: no valid pulse after reset release.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled at edge T. If any is pending, the winner is latched and the FSM goes to ISSUE.
- ISSUE (cycle T+1):
  - MemAddrOut is the winner's address.
  - The winner's gnt is high for exactly this cycle.
  - Writes: MemWE=1 and MemDataOut=wdata for this cycle only; next state is DONE.
  - Reads: MemWE=0; next state is WAIT.
- WAIT:
  - Counts RD_LAT cycles while MemAddrOut is held.
  - On the last edge, MemDataIN is registered into the winner's data register.
  - Next state is DONE.
- DONE:
  - The winner's valid pulse is high for one cycle.
  - The arbiter evaluates requests in the same cycle as in IDLE, giving back-to-back service.
  - Next state is ISSUE if a request is pending, else IDLE.
- Latency, measured from the sampling edge:
  - Read: gnt at +1, valid at +2+RD_LAT (RD_LAT=1: valid 3 cycles after request sampled).
  - Write: valid at +2.
- Throughput: one read every 2+RD_LAT cycles; one write every 2 cycles.
- Arbitration when both requests are pending:
  - in_blank=1: RTC wins.
  - in_blank=0: VGA wins, unless wait_cnt ≥ MAX_WAIT, in which case RTC wins.
  - A single requester always wins.
- wait_cnt (8-bit):
  - Increments each cycle rtc_req=1 without rtc_gnt.
  - Saturates at 255.
  - Clears on rtc_gnt or when rtc_req=0.
- Request handling:
  - Requests are never queued.
  - A req still high in the cycle after its gnt counts as a new request.
  - Address, write-enable and write-data changes before gnt are tolerated; they are latched at the arbitration edge.
- MemAddrOut retains its last value in IDLE. MemDataOut is 0 when MemWE=0.
- in_blank only affects arbitration decisions; it never aborts an issued transaction.

Test Plan:
- Bank preset mem[1]=30, mem[2]=15, mem[3]=3, RD_LAT=1, in_blank=0. VGA reads addr 2 -> vga_gnt 1 cycle after req sampled; vga_valid 3 cycles after, vga_data=15; rtc outputs stay 0.
- RTC writes addr 1 with wdata 45 -> MemWE=1 for exactly one cycle with MemAddrOut=1, MemDataOut=45. rtc_valid follows 1 cycle later. A subsequent RTC read of addr 1 returns rtc_rdata=45.
- Both requests held, with VGA continuously re-requesting.
  - in_blank=0, MAX_WAIT=8: VGA is served until wait_cnt reaches 8, then the RTC is granted once and VGA resumes.
  - in_blank=1: the RTC is granted first.
- Back-to-back reads: VGA reads addr 1 then addr 3. The second gnt falls in the DONE cycle of the first plus 1. vga_valid pulses carry 30 then 3, 3 cycles apart.
- RESET asserted in the WAIT state of an RTC read -> all outputs 0 asynchronously, and no rtc_valid after release. A new VGA read of addr 3 after release returns 3 with nominal latency.
- RD_LAT=3 build: VGA read of addr 2 -> vga_valid 5 cycles after sampling, with MemAddrOut held at 2 throughout WAIT.

Source files
------------

// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_arbiter
//  Description : Shares the single-port 16x8 time/chronometer register bank
//                between the VGA display reader and the RTC read/write port.
//  Revision    : 1.0 - initial release
// ============================================================================

module regbank_arbiter #(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in_blank,
    input  logic       vga_req,
    input  logic [3:0] vga_addr,
    output logic       vga_gnt,
    output logic [7:0] vga_data,
    output logic       vga_valid,
    input  logic       rtc_req,
    input  logic       rtc_we,
    input  logic [3:0] rtc_addr,
    input  logic [7:0] rtc_wdata,
    output logic       rtc_gnt,
    output logic [7:0] rtc_rdata,
    output logic       rtc_valid,
    output logic [3:0] MemAddrOut,
    output logic [7:0] MemDataOut,
    output logic       MemWE,
    input  logic [7:0] MemDataIN
);

    localparam logic [1:0] LAT_LAST   = 2'(RD_LAT - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [7:0] WAIT_SAT   = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q,     state_d;
    logic       sel_rtc_q,   sel_rtc_d;
    logic [1:0] lat_cnt_q,   lat_cnt_d;
    logic [7:0] wait_cnt_q,  wait_cnt_d;
    logic       vga_gnt_q,   vga_gnt_d;
    logic       rtc_gnt_q,   rtc_gnt_d;
    logic       vga_valid_q, vga_valid_d;
    logic       rtc_valid_q, rtc_valid_d;
    logic [7:0] vga_data_q,  vga_data_d;
    logic [7:0] rtc_rdata_q, rtc_rdata_d;
    logic [3:0] mem_addr_q,  mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       mem_we_q,    mem_we_d;

    logic any_req;
    logic pick_rtc;
    logic pick_wr;

    // RTC wins in blanking, when alone, or once it has starved long enough.
    always_comb begin
        any_req  = vga_req | rtc_req;
        pick_rtc = rtc_req & (~vga_req | in_blank | (wait_cnt_q >= WAIT_LIMIT));
        pick_wr  = pick_rtc & rtc_we;
    end

    always_comb begin
        if (!rtc_req || rtc_gnt_q) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_rtc_d   = sel_rtc_q;
        lat_cnt_d   = lat_cnt_q;
        vga_gnt_d   = 1'b0;
        rtc_gnt_d   = 1'b0;
        vga_valid_d = 1'b0;
        rtc_valid_d = 1'b0;
        vga_data_d  = vga_data_q;
        rtc_rdata_d = rtc_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = 8'd0;
        mem_we_d    = 1'b0;

        case (state_q)
            // DONE arbitrates exactly like IDLE so service can run back-to-back.
            S_IDLE, S_DONE: begin
                if (any_req) begin
                    state_d     = S_ISSUE;
                    sel_rtc_d   = pick_rtc;
                    lat_cnt_d   = 2'd0;
                    vga_gnt_d   = ~pick_rtc;
                    rtc_gnt_d   = pick_rtc;
                    mem_addr_d  = pick_rtc ? rtc_addr : vga_addr;
                    mem_we_d    = pick_wr;
                    mem_wdata_d = pick_wr ? rtc_wdata : 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    state_d     = S_DONE;
                    rtc_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = S_DONE;
                    if (sel_rtc_q) begin
                        rtc_rdata_d = MemDataIN;
                        rtc_valid_d = 1'b1;
                    end else begin
                        vga_data_d  = MemDataIN;
                        vga_valid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            sel_rtc_q   <= 1'b0;
            lat_cnt_q   <= 2'd0;
            wait_cnt_q  <= 8'd0;
            vga_gnt_q   <= 1'b0;
            rtc_gnt_q   <= 1'b0;
            vga_valid_q <= 1'b0;
            rtc_valid_q <= 1'b0;
            vga_data_q  <= 8'd0;
            rtc_rdata_q <= 8'd0;
            mem_addr_q  <= 4'd0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_rtc_q   <= sel_rtc_d;
            lat_cnt_q   <= lat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            vga_gnt_q   <= vga_gnt_d;
            rtc_gnt_q   <= rtc_gnt_d;
            vga_valid_q <= vga_valid_d;
            rtc_valid_q <= rtc_valid_d;
            vga_data_q  <= vga_data_d;
            rtc_rdata_q <= rtc_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign vga_gnt    = vga_gnt_q;
    assign vga_data   = vga_data_q;
    assign vga_valid  = vga_valid_q;
    assign rtc_gnt    = rtc_gnt_q;
    assign rtc_rdata  = rtc_rdata_q;
    assign rtc_valid  = rtc_valid_q;
    assign MemAddrOut = mem_addr_q;
    assign MemDataOut = mem_wdata_q;
    assign MemWE      = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbank_arbiter
//  Description : Directed bench for regbank_arbiter with behavioural banks
//                (RD_LAT=1 instance and RD_LAT=3 instance).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_regbank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: RD_LAT=1, MAX_WAIT=8
    logic       in_blank, vga_req, rtc_req, rtc_we;
    logic [3:0] vga_addr, rtc_addr;
    logic [7:0] rtc_wdata, mem_din;
    logic       vga_gnt, vga_valid, rtc_gnt, rtc_valid, mem_we;
    logic [7:0] vga_data, rtc_rdata, mem_dout;
    logic [3:0] mem_addr;

    // Instance B: RD_LAT=3, VGA side only exercised
    logic       b_in_blank, b_vga_req, b_rtc_req, b_rtc_we;
    logic [3:0] b_vga_addr, b_rtc_addr;
    logic [7:0] b_rtc_wdata, b_mem_din;
    logic       b_vga_gnt, b_vga_valid, b_rtc_gnt, b_rtc_valid, b_mem_we;
    logic [7:0] b_vga_data, b_rtc_rdata, b_mem_dout;
    logic [3:0] b_mem_addr;

    regbank_arbiter #(.RD_LAT(1), .MAX_WAIT(8)) dut_a (
        .CLK(clk), .RESET(rst_n), .in_blank(in_blank),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_data(vga_data), .vga_valid(vga_valid),
        .rtc_req(rtc_req), .rtc_we(rtc_we), .rtc_addr(rtc_addr),
        .rtc_wdata(rtc_wdata), .rtc_gnt(rtc_gnt), .rtc_rdata(rtc_rdata),
        .rtc_valid(rtc_valid), .MemAddrOut(mem_addr), .MemDataOut(mem_dout),
        .MemWE(mem_we), .MemDataIN(mem_din)
    );

    regbank_arbiter #(.RD_LAT(3), .MAX_WAIT(8)) dut_b (
        .CLK(clk), .RESET(rst_n), .in_blank(b_in_blank),
        .vga_req(b_vga_req), .vga_addr(b_vga_addr), .vga_gnt(b_vga_gnt),
        .vga_data(b_vga_data), .vga_valid(b_vga_valid),
        .rtc_req(b_rtc_req), .rtc_we(b_rtc_we), .rtc_addr(b_rtc_addr),
        .rtc_wdata(b_rtc_wdata), .rtc_gnt(b_rtc_gnt), .rtc_rdata(b_rtc_rdata),
        .rtc_valid(b_rtc_valid), .MemAddrOut(b_mem_addr), .MemDataOut(b_mem_dout),
        .MemWE(b_mem_we), .MemDataIN(b_mem_din)
    );

    // Behavioural banks: A has one registered read stage, B has three.
    logic [7:0] mem_a [16] = '{8'd0, 8'd30, 8'd15, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0,
                               8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] mem_b [16] = '{8'd0, 8'd30, 8'd15, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0,
                               8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] b_p1, b_p2;

    always @(posedge clk) begin
        if (mem_we) mem_a[mem_addr] <= mem_dout;
        mem_din <= mem_a[mem_addr];
        b_p1      <= mem_b[b_mem_addr];
        b_p2      <= b_p1;
        b_mem_din <= b_p2;
    end

    logic [32:0] outs_a, outs_b;
    assign outs_a = {vga_gnt, vga_valid, vga_data, rtc_gnt, rtc_rdata, rtc_valid,
                     mem_addr, mem_dout, mem_we};
    assign outs_b = {b_vga_gnt, b_vga_valid, b_vga_data, b_rtc_gnt, b_rtc_rdata,
                     b_rtc_valid, b_mem_addr, b_mem_dout, b_mem_we};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rtc;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       blank;
        int         gnt_at;
        int         valid_at;
        logic       chk;
        logic [7:0] data;
    } vec_t;

    vec_t vt [10];

    // One isolated transaction on instance A; cycle numbers count negedges
    // after the edge at which the request is first sampled.
    task automatic run_vec(input vec_t v, output int g_at, output int v_at,
                           output int we_n, output int other_n,
                           output logic [3:0] g_addr, output logic [7:0] g_wd,
                           output logic [7:0] rd);
        @(negedge clk);
        in_blank = v.blank;
        if (v.rtc) begin
            rtc_req = 1'b1; rtc_we = v.we; rtc_addr = v.addr; rtc_wdata = v.wdata;
        end else begin
            vga_req = 1'b1; vga_addr = v.addr;
        end
        g_at = -1; v_at = -1; we_n = 0; other_n = 0; g_addr = '0; g_wd = '0; rd = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) we_n++;
            if (v.rtc ? rtc_gnt : vga_gnt) begin
                if (g_at < 0) begin
                    g_at = c; g_addr = mem_addr; g_wd = mem_dout;
                end
                rtc_req = 1'b0; vga_req = 1'b0;
            end
            if (v.rtc ? rtc_valid : vga_valid) begin
                if (v_at < 0) v_at = c;
                rd = v.rtc ? rtc_rdata : vga_data;
            end
            if (v.rtc ? (vga_gnt | vga_valid) : (rtc_gnt | rtc_valid)) other_n++;
        end
        rtc_req = 1'b0; vga_req = 1'b0; in_blank = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g_at, v_at, we_n, other_n, ng, nv, vbefore, rg_at, rv_at, va_at, pulses, bad;
        int g [2];
        int vv [2];
        logic [7:0] vd [2];
        logic [3:0] g_addr;
        logic [7:0] g_wd, rd, rdat;

        //           rtc   we    addr   wdata   blank gnt val chk   data
        vt[0] = '{1'b0, 1'b0, 4'd2, 8'h00, 1'b0, 1, 3, 1'b1, 8'd15};
        vt[1] = '{1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1, 3, 1'b1, 8'd3};
        vt[2] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1, 3, 1'b1, 8'd15};
        vt[3] = '{1'b1, 1'b1, 4'd1, 8'd45, 1'b0, 1, 2, 1'b0, 8'd0};
        vt[4] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1, 3, 1'b1, 8'd45};
        vt[5] = '{1'b0, 1'b0, 4'd1, 8'h00, 1'b1, 1, 3, 1'b1, 8'd45};
        vt[6] = '{1'b1, 1'b1, 4'd5, 8'hA5, 1'b1, 1, 2, 1'b0, 8'd0};
        vt[7] = '{1'b0, 1'b0, 4'd5, 8'h00, 1'b0, 1, 3, 1'b1, 8'hA5};
        vt[8] = '{1'b1, 1'b1, 4'd0, 8'hFF, 1'b0, 1, 2, 1'b0, 8'd0};
        vt[9] = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1, 3, 1'b1, 8'hFF};

        rst_n = 1'b0;
        in_blank = 0; vga_req = 0; vga_addr = 0; rtc_req = 0; rtc_we = 0;
        rtc_addr = 0; rtc_wdata = 0;
        b_in_blank = 0; b_vga_req = 0; b_vga_addr = 0; b_rtc_req = 0; b_rtc_we = 0;
        b_rtc_addr = 0; b_rtc_wdata = 0;
        repeat (3) @(negedge clk);
        check("reset outs A", 64'(outs_a), 64'd0);
        check("reset outs B", 64'(outs_b), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back VGA reads: addr 1 then addr 3
        @(negedge clk);
        vga_req = 1'b1; vga_addr = 4'd1;
        ng = 0; nv = 0; other_n = 0;
        g[0] = -1; g[1] = -1; vv[0] = -1; vv[1] = -1; vd[0] = '0; vd[1] = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (vga_gnt) begin
                if (ng < 2) g[ng] = c;
                ng++;
                if (ng == 1) vga_addr = 4'd3;
                else vga_req = 1'b0;
            end
            if (vga_valid) begin
                if (nv < 2) begin vv[nv] = c; vd[nv] = vga_data; end
                nv++;
            end
            if (rtc_gnt | rtc_valid) other_n++;
        end
        vga_req = 1'b0;
        check("b2b gnt count", 64'(ng), 64'd2);
        check("b2b gnt1 cycle", 64'(g[0]), 64'd1);
        check("b2b gnt2 cycle", 64'(g[1]), 64'd4);
        check("b2b valid1 cycle", 64'(vv[0]), 64'd3);
        check("b2b valid2 cycle", 64'(vv[1]), 64'd6);
        check("b2b data1", 64'(vd[0]), 64'd30);
        check("b2b data2", 64'(vd[1]), 64'd3);
        check("b2b rtc pulses", 64'(other_n), 64'd0);
        check("b2b rtc_rdata", 64'(rtc_rdata), 64'd0);

        // Table of isolated transactions
        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], g_at, v_at, we_n, other_n, g_addr, g_wd, rd);
            check($sformatf("v%0d gnt_at", i), 64'(g_at), 64'(vt[i].gnt_at));
            check($sformatf("v%0d valid_at", i), 64'(v_at), 64'(vt[i].valid_at));
            check($sformatf("v%0d addr", i), 64'(g_addr), 64'(vt[i].addr));
            check($sformatf("v%0d wdata", i), 64'(g_wd), vt[i].we ? 64'(vt[i].wdata) : 64'd0);
            check($sformatf("v%0d we_cycles", i), 64'(we_n), vt[i].we ? 64'd1 : 64'd0);
            check($sformatf("v%0d other", i), 64'(other_n), 64'd0);
            if (vt[i].chk) check($sformatf("v%0d data", i), 64'(rd), 64'(vt[i].data));
        end

        // Starvation guard: both pending in active video, VGA re-requesting
        @(negedge clk);
        in_blank = 1'b0; vga_req = 1'b1; vga_addr = 4'd2;
        rtc_req = 1'b1; rtc_we = 1'b0; rtc_addr = 4'd3;
        vbefore = 0; rg_at = -1; rv_at = -1; va_at = -1; rdat = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rtc_gnt) begin
                if (rg_at < 0) rg_at = c;
                rtc_req = 1'b0;
            end
            if (vga_gnt) begin
                if (rg_at < 0) vbefore++;
                else if (va_at < 0) va_at = c;
            end
            if (rtc_valid) begin rv_at = c; rdat = rtc_rdata; end
        end
        vga_req = 1'b0;
        repeat (6) @(negedge clk);
        check("starve vga before rtc", 64'(vbefore), 64'd3);
        check("starve rtc gnt cycle", 64'(rg_at), 64'd10);
        check("starve rtc valid cycle", 64'(rv_at), 64'd12);
        check("starve rtc data", 64'(rdat), 64'd3);
        check("starve vga resumes", 64'(va_at), 64'd13);

        // Blanking: RTC wins first
        @(negedge clk);
        in_blank = 1'b1; vga_req = 1'b1; vga_addr = 4'd2;
        rtc_req = 1'b1; rtc_we = 1'b0; rtc_addr = 4'd2;
        rg_at = -1; va_at = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rtc_gnt) begin
                if (rg_at < 0) rg_at = c;
                rtc_req = 1'b0;
            end
            if (vga_gnt) begin
                if (va_at < 0) va_at = c;
                vga_req = 1'b0;
            end
        end
        in_blank = 1'b0; vga_req = 1'b0; rtc_req = 1'b0;
        repeat (4) @(negedge clk);
        check("blank rtc gnt cycle", 64'(rg_at), 64'd1);
        check("blank vga gnt cycle", 64'(va_at), 64'd4);

        // Reset during WAIT of an RTC read
        @(negedge clk);
        rtc_req = 1'b1; rtc_we = 1'b0; rtc_addr = 4'd2;
        @(negedge clk);
        check("rst rtc gnt", 64'(rtc_gnt), 64'd1);
        rtc_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst async outs", 64'(outs_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rtc_valid | rtc_gnt | vga_gnt | vga_valid) pulses++;
        end
        check("rst no pulses after", 64'(pulses), 64'd0);
        check("rst rtc_rdata cleared", 64'(rtc_rdata), 64'd0);
        run_vec('{1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1, 3, 1'b1, 8'd3},
                g_at, v_at, we_n, other_n, g_addr, g_wd, rd);
        check("post-rst gnt_at", 64'(g_at), 64'd1);
        check("post-rst valid_at", 64'(v_at), 64'd3);
        check("post-rst data", 64'(rd), 64'd3);

        // RD_LAT=3 instance
        @(negedge clk);
        b_vga_req = 1'b1; b_vga_addr = 4'd2;
        g_at = -1; v_at = -1; rd = '0; bad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (b_vga_gnt) begin
                if (g_at < 0) g_at = c;
                b_vga_req = 1'b0;
            end
            if (b_vga_valid) begin
                if (v_at < 0) v_at = c;
                rd = b_vga_data;
            end
            if (c <= 5 && b_mem_addr != 4'd2) bad++;
        end
        b_vga_req = 1'b0;
        check("lat3 gnt_at", 64'(g_at), 64'd1);
        check("lat3 valid_at", 64'(v_at), 64'd5);
        check("lat3 data", 64'(rd), 64'd15);
        check("lat3 addr held", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
